// File: rtl/serial_subtractor_4bit_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_subtractor_4bit_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Bit counter width for a given operand width, never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_4bit_full_subtractor_1bit.sv
// One-bit full subtractor cell, x - y - bin, built from discrete gates.
module full_subtractor_1bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic xy;
    logic xy_n;
    logic x_n;
    logic t0;
    logic t1;

    xor g_xy   (xy, x, y);
    xor g_diff (diff, xy, bin);
    not g_xn   (x_n, x);
    and g_t0   (t0, x_n, y);
    not g_xyn  (xy_n, xy);
    and g_t1   (t1, xy_n, bin);
    or  g_bout (bout, t0, t1);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial two's-complement subtractor d = a - b, LSB first, with start/busy/done handshake.
//
// state   | meaning
// S_IDLE  | waiting for start; d/bout hold the last result
// S_SHIFT | one difference bit produced per clock
// S_DONE  | done pulse; a new start is accepted here as in S_IDLE
module serial_subtractor_4bit
    import serial_subtractor_4bit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             diff;
    logic             borrow_next;

    full_subtractor_1bit u_fs (
        .x    (areg[0]),
        .y    (breg[0]),
        .bin  (borrow),
        .diff (diff),
        .bout (borrow_next)
    );

    // busy is its own flop so it is a clean register output rather than a state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
            bout   <= 1'b0;
            areg   <= '0;
            breg   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        areg   <= a;
                        breg   <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        d      <= '0;
                        busy   <= 1'b1;
                        state  <= S_SHIFT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    d      <= {diff, d[WIDTH-1:1]};
                    areg   <= areg >> 1;
                    breg   <= breg >> 1;
                    borrow <= borrow_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        bout  <= borrow_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Directed and exhaustive checks of serial_subtractor_4bit at WIDTH=4.
module tb_serial_subtractor_4bit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [3:0] d;
    logic       bout;

    int errors = 0;
    int checks = 0;

    serial_subtractor_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge: launches one operation and returns at the negedge where done is seen.
    task automatic do_op(input logic [3:0] ta, input logic [3:0] tb, output int lat, output int nbusy);
        start = 1'b1;
        a     = ta;
        b     = tb;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = 4'hx;
        b     = 4'hx;
        lat   = 1;
        nbusy = 0;
        while (!done && lat < 20) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int nbusy;
        int pulses;
        logic [3:0] cap_d;
        logic       cap_bout;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_d", d, 0);
        check("reset_bout", bout, 0);
        rst = 1'b0;
        @(negedge clk);

        // 9 - 4: latency, busy length and done pulse width
        do_op(4'd9, 4'd4, lat, nbusy);
        check("9m4_latency", lat, 5);
        check("9m4_busy_cycles", nbusy, 4);
        check("9m4_busy_at_done", busy, 0);
        check("9m4_d", d, 5);
        check("9m4_bout", bout, 0);
        @(negedge clk);
        check("9m4_done_low", done, 0);
        check("9m4_d_hold", d, 5);

        do_op(4'd3, 4'd7, lat, nbusy);
        check("3m7_d", d, 12);
        check("3m7_bout", bout, 1);
        @(negedge clk);
        do_op(4'd0, 4'd1, lat, nbusy);
        check("0m1_d", d, 15);
        check("0m1_bout", bout, 1);
        @(negedge clk);
        do_op(4'd15, 4'd15, lat, nbusy);
        check("15m15_d", d, 0);
        check("15m15_bout", bout, 0);
        @(negedge clk);

        // start while busy is ignored
        start = 1'b1;
        a     = 4'd6;
        b     = 4'd2;
        @(posedge clk);
        pulses   = 0;
        cap_d    = 4'hf;
        cap_bout = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 2) begin
                start = 1'b1;
                a     = 4'd1;
                b     = 4'd8;
            end
            if (i == 3) start = 1'b0;
            if (done) begin
                pulses++;
                cap_d    = d;
                cap_bout = bout;
            end
        end
        check("busy_start_pulses", pulses, 1);
        check("busy_start_d", cap_d, 4);
        check("busy_start_bout", cap_bout, 0);

        // start during the done cycle: no idle gap
        do_op(4'd9, 4'd4, lat, nbusy);
        check("b2b_first_d", d, 5);
        start = 1'b1;
        a     = 4'd10;
        b     = 4'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_no_gap", busy, 1);
        check("b2b_done_cleared", done, 0);
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_done_spacing", lat, 5);
        check("b2b_d", d, 7);
        check("b2b_bout", bout, 0);
        @(negedge clk);

        // reset mid-operation
        start = 1'b1;
        a     = 4'd12;
        b     = 4'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_d", d, 0);
        check("abort_bout", bout, 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        do_op(4'd12, 4'd5, lat, nbusy);
        check("after_abort_d", d, 7);
        check("after_abort_bout", bout, 0);
        @(negedge clk);

        // exhaustive sweep
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic [3:0] ea;
                logic [3:0] eb;
                logic [3:0] ed;
                ea = 4'(i);
                eb = 4'(j);
                ed = ea - eb;
                do_op(ea, eb, lat, nbusy);
                check($sformatf("sweep_lat_%0d_%0d", i, j), lat, 5);
                check($sformatf("sweep_d_%0d_%0d", i, j), d, ed);
                check($sformatf("sweep_bout_%0d_%0d", i, j), bout, (i < j) ? 1 : 0);
                @(negedge clk);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
